pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator, successor to the fixed 16-output, single-duty PWM peripheral. Provides NUM_CH outputs from one shared period counter, with per-channel duty cycles, a clock prescaler, edge- or center-aligned counting, and double-buffered (shadow) configuration that applies only at period boundaries. Sits between the SPI register file and the top-level output pins `{uio_out, uo_out}`.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_timebase.sv | 104 ++++++++++
 rtl/pwm_multichannel.sv | 102 ++++++++++
 tb/tb_pwm_multichannel.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants for the multi-channel PWM generator. Holds
//               the counting-mode and count-direction encodings and the
//               default parameter values used by pwm_timebase and
//               pwm_multichannel.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Counting mode, as carried by center_mode / mode_act
    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // Counter direction (only meaningful in center mode)
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Default parameter values
    localparam int unsigned DEF_NUM_CH  = 16;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_PRESC_W = 8;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : Shared period timebase. A prescaler produces count ticks,
//               and the counter runs edge-aligned (0..TOP, 0) or
//               center-aligned (0..TOP, TOP-1..1, 0). TOP, prescale and
//               mode are shadowed and taken from the inputs only at a
//               period boundary.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               period_top    - TOP value, loaded at boundary
//               prescale      - clock divide minus one, loaded at boundary
//               center_mode   - 0 edge, 1 center, loaded at boundary
//               cnt           - current counter value
//               boundary      - high on the cycle that ends a period
//               mode_act      - active counting mode
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   period_top,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [CNT_W-1:0]   cnt,
    output logic               boundary,
    output logic               mode_act
);

    localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);
    localparam logic [PRESC_W-1:0] c_psc_one = PRESC_W'(1);

    logic [PRESC_W-1:0] r_psc;
    logic [PRESC_W-1:0] r_presc_act;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_top_act;
    logic               r_dir;
    logic               r_mode_act;

    logic               w_tick;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_dir_next;

    // psc never passes presc_act: presc_act only changes on a tick, when
    // psc is simultaneously returned to zero.
    assign w_tick = (r_psc == r_presc_act);

    // Next counter value on a tick. A result of zero marks a boundary; the
    // ">=" compares keep the sequence bounded even for TOP=0.
    always_comb begin
        w_cnt_next = '0;
        w_dir_next = r_dir;
        if (r_mode_act == PWM_MODE_CENTER) begin
            if (r_dir == DIR_UP) begin
                if (r_cnt >= r_top_act) begin
                    w_cnt_next = (r_top_act == '0) ? '0 : (r_top_act - c_cnt_one);
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end else begin
                w_cnt_next = (r_cnt == '0) ? '0 : (r_cnt - c_cnt_one);
            end
        end else begin
            w_cnt_next = (r_cnt >= r_top_act) ? '0 : (r_cnt + c_cnt_one);
        end
    end

    assign boundary = w_tick && (w_cnt_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc       <= '0;
            r_presc_act <= '0;
            r_cnt       <= '0;
            r_top_act   <= '0;
            r_dir       <= DIR_UP;
            r_mode_act  <= PWM_MODE_EDGE;
        end else if (w_tick) begin
            r_psc <= '0;
            if (boundary) begin
                r_cnt       <= '0;
                r_dir       <= DIR_UP;
                r_top_act   <= period_top;
                r_presc_act <= prescale;
                r_mode_act  <= center_mode;
            end else begin
                r_cnt <= w_cnt_next;
                r_dir <= w_dir_next;
            end
        end else begin
            r_psc <= r_psc + c_psc_one;
        end
    end

    assign cnt      = r_cnt;
    assign mode_act = r_mode_act;

endmodule : pwm_timebase
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multichannel
// Description : NUM_CH-channel PWM generator sharing one pwm_timebase.
//               Each channel has a duty shadow register written through a
//               strobe interface and an active duty register reloaded from
//               the shadow at every period boundary.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               en_out        - per-channel output enable (0 forces low)
//               en_pwm        - per-channel PWM enable (0 drives high)
//               duty_we       - duty write strobe
//               duty_ch       - channel index of the write
//               duty_data     - duty value for the write
//               period_top    - TOP value (shadowed)
//               prescale      - clock divide minus one (shadowed)
//               center_mode   - 0 edge, 1 center (shadowed)
//               out           - registered PWM outputs
//               period_tick   - one-cycle pulse after each boundary
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter  int unsigned NUM_CH  = DEF_NUM_CH,
    parameter  int unsigned CNT_W   = DEF_CNT_W,
    parameter  int unsigned PRESC_W = DEF_PRESC_W,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic               duty_we,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [CNT_W-1:0]   duty_data,
    input  logic [CNT_W-1:0]   period_top,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [NUM_CH-1:0]  out,
    output logic               period_tick
);

    logic [CNT_W-1:0]  w_cnt;
    logic              w_boundary;
    logic              w_mode_act_unused;
    logic [NUM_CH-1:0] w_chan;
    logic [NUM_CH-1:0] r_out;
    logic              r_period_tick;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .period_top  (period_top),
        .prescale    (prescale),
        .center_mode (center_mode),
        .cnt         (w_cnt),
        .boundary    (w_boundary),
        .mode_act    (w_mode_act_unused)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_duty_sh;
        logic [CNT_W-1:0] r_duty_act;

        // Indices >= NUM_CH match no channel, so such writes fall away.
        // On a boundary the active register takes the shadow's old value,
        // so a write landing on that same cycle waits one more period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_duty_sh  <= '0;
                r_duty_act <= '0;
            end else begin
                if (duty_we && (duty_ch == CH_W'(gi))) begin
                    r_duty_sh <= duty_data;
                end
                if (w_boundary) begin
                    r_duty_act <= r_duty_sh;
                end
            end
        end

        assign w_chan[gi] = en_out[gi] & (~en_pwm[gi] | (w_cnt < r_duty_act));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out         <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_out         <= w_chan;
            r_period_tick <= w_boundary;
        end
    end

    assign out         = r_out;
    assign period_tick = r_period_tick;

endmodule : pwm_multichannel
`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multichannel
// Description : Directed self-checking bench for pwm_multichannel with
//               NUM_CH=12. Expected high counts and periods are worked out
//               by hand from TOP, prescale and duty settings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multichannel;

    localparam int unsigned NUM_CH  = 12;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PRESC_W = 8;
    localparam int unsigned CH_W    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_CH-1:0]  en_out;
    logic [NUM_CH-1:0]  en_pwm;
    logic               duty_we;
    logic [CH_W-1:0]    duty_ch;
    logic [CNT_W-1:0]   duty_data;
    logic [CNT_W-1:0]   period_top;
    logic [PRESC_W-1:0] prescale;
    logic               center_mode;
    logic [NUM_CH-1:0]  out;
    logic               period_tick;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_out      (en_out),
        .en_pwm      (en_pwm),
        .duty_we     (duty_we),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
        .period_top  (period_top),
        .prescale    (prescale),
        .center_mode (center_mode),
        .out         (out),
        .period_tick (period_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_duty(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
        duty_we   = 1'b1;
        duty_ch   = ch;
        duty_data = d;
        step(1);
        duty_we   = 1'b0;
    endtask

    task automatic measure(input int ch, input int n, output int hi, output int tk);
        hi = 0;
        tk = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            if (out[ch]) hi++;
            if (period_tick) tk++;
        end
    endtask

    // Returns on the sample where period_tick is high (or after max cycles).
    task automatic wait_tick(input int max, input string tag);
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!period_tick && k < max);
        chk({tag, "_seen"}, 32'(period_tick), 32'd1);
    endtask

    task automatic spacing(input int max, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!period_tick && n < max);
    endtask

    initial begin
        int hi, tk, n;
        int exp_inv [NUM_CH];

        rst         = 1'b1;
        en_out      = '0;
        en_pwm      = '0;
        duty_we     = 1'b0;
        duty_ch     = '0;
        duty_data   = '0;
        period_top  = '0;
        prescale    = '0;
        center_mode = 1'b0;

        // ---- reset state
        step(2);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);

        // ---- release: first clock is a boundary that loads TOP=9
        period_top = 8'd9;
        en_out     = '1;
        en_pwm     = '1;
        rst        = 1'b0;
        step(1);
        chk("release_boundary", 32'(period_tick), 32'd1);
        step(1);
        chk("release_tick_width", 32'(period_tick), 32'd0);

        // ---- edge mode, TOP=9, presc=0, duty[0]=3
        write_duty(4'd0, 8'd3);
        write_duty(4'd2, 8'd2);
        wait_tick(20, "edge_sync");
        measure(0, 100, hi, tk);
        chk("edge_hi", 32'(hi), 32'd30);
        chk("edge_ticks", 32'(tk), 32'd10);
        measure(1, 100, hi, tk);
        chk("edge_duty0_hi", 32'(hi), 32'd0);
        wait_tick(20, "edge_sp");
        spacing(40, n);
        chk("edge_period", 32'(n), 32'd10);

        // ---- center mode, TOP=4, presc=1: cnt 0,1,2,3,4,3,2,1 at 2 clocks each
        center_mode = 1'b1;
        period_top  = 8'd4;
        prescale    = 8'd1;
        wait_tick(20, "ctr_sync");
        measure(2, 64, hi, tk);
        chk("ctr_duty2_hi", 32'(hi), 32'd24);   // cnt<2: 0,1,1 -> 6 of 16
        chk("ctr_ticks", 32'(tk), 32'd4);
        measure(0, 64, hi, tk);
        chk("ctr_duty3_hi", 32'(hi), 32'd40);   // cnt<3: 0,1,2,2,1 -> 10 of 16
        wait_tick(40, "ctr_sp");
        spacing(40, n);
        chk("ctr_period", 32'(n), 32'd16);

        // ---- extremes: TOP=254, duty 255 always high, duty 0 always low
        write_duty(4'd3, 8'd255);
        center_mode = 1'b0;
        period_top  = 8'd254;
        prescale    = 8'd0;
        wait_tick(40, "ext_sync");
        measure(3, 300, hi, tk);
        chk("ext_duty255_hi", 32'(hi), 32'd300);
        measure(1, 300, hi, tk);
        chk("ext_duty0_hi", 32'(hi), 32'd0);

        en_pwm[1] = 1'b0;
        chk("en_pwm_before", 32'(out[1]), 32'd0);
        step(1);
        chk("en_pwm_after", 32'(out[1]), 32'd1);
        en_out[3] = 1'b0;
        chk("en_out_before", 32'(out[3]), 32'd1);
        step(1);
        chk("en_out_after", 32'(out[3]), 32'd0);

        // ---- shadow timing, TOP=15. E = boundary that loads TOP=15.
        period_top = 8'd15;
        wait_tick(300, "shd_sync");
        step(5);                        // E+5, cnt=5
        write_duty(4'd5, 8'd7);         // captured at E+6
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);                    // samples E+7..E+16
            if (out[5]) hi++;
        end
        chk("shd_hold", 32'(hi), 32'd0);
        chk("shd_boundary", 32'(period_tick), 32'd1);
        step(1);                        // E+17
        chk("shd_apply", 32'(out[5]), 32'd1);
        hi = 1;
        for (int k = 0; k < 15; k++) begin
            step(1);                    // samples E+18..E+32
            if (out[5]) hi++;
        end
        chk("shd_period_hi", 32'(hi), 32'd7);
        step(15);                       // E+47
        write_duty(4'd5, 8'd2);         // captured on boundary edge E+48
        chk("shd_wb_boundary", 32'(period_tick), 32'd1);
        measure(5, 16, hi, tk);
        chk("shd_wb_old", 32'(hi), 32'd7);
        measure(5, 16, hi, tk);
        chk("shd_wb_new", 32'(hi), 32'd2);

        // ---- invalid channel writes leave every shadow untouched
        write_duty(4'd13, 8'd200);
        write_duty(4'd12, 8'd200);
        write_duty(4'd15, 8'd200);
        wait_tick(40, "inv_sync");
        exp_inv = '{6, 32, 4, 0, 0, 4, 0, 0, 0, 0, 0, 0};
        for (int c = 0; c < int'(NUM_CH); c++) begin
            measure(c, 32, hi, tk);
            chk($sformatf("inv_ch%0d", c), 32'(hi), 32'(exp_inv[c]));
        end

        // ---- asynchronous reset mid-period with out[1] high
        chk("pre_rst_out1", 32'(out[1]), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_out", 32'(out), 32'd0);
        chk("rst_mid_tick", 32'(period_tick), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_rel_boundary", 32'(period_tick), 32'd1);
        chk("rst_rel_out", 32'(out), 32'h002);
        step(1);
        chk("rst_rel_tick_width", 32'(period_tick), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_pwm_multichannel
`default_nettype wire
